// File: rtl/id_ex_hazard_stage.sv
// ID/EX pipeline register for the 5-stage RISC-V core.
//
// Captures the decoded instruction into the EX-stage register set. It also
// detects load-use hazards against the load currently in EX, and inserts
// bubbles for load-use stalls and taken-branch flushes. Two saturating
// counters record how many bubbles each cause has inserted.
//
// Ports:
//   clk, rst            core clock; synchronous active-high reset
//   *_id                decode-stage instruction fields and control bits
//   br_taken_ex         EX resolved a taken branch/jump this cycle
//   hold                memory-side freeze; ID/EX and counters keep value
//   *_ex                registered ID/EX fields for forwarding and EX
//   stall_if_id         combinational: hold PC and IF/ID this cycle
//   flush_id            combinational: squash IF/ID this cycle
//   lu_bubbles          saturating count of load-use bubbles
//   br_bubbles          saturating count of branch-flush bubbles
module id_ex_hazard_stage #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  // decode side
  input  logic             valid_id,
  input  logic [XLEN-1:0]  pc_id,
  input  logic [XLEN-1:0]  imm_id,
  input  logic [XLEN-1:0]  rs1_data_id,
  input  logic [XLEN-1:0]  rs2_data_id,
  input  logic [4:0]       rs1_id,
  input  logic [4:0]       rs2_id,
  input  logic [4:0]       rd_id,
  input  logic             uses_rs1_id,
  input  logic             uses_rs2_id,
  input  logic             RUWr_id,
  input  logic             MemRd_id,
  input  logic             MemWr_id,
  input  logic             Branch_id,
  input  logic [3:0]       ALUOp_id,
  // pipeline control
  input  logic             br_taken_ex,
  input  logic             hold,
  // execute side
  output logic             valid_ex,
  output logic [XLEN-1:0]  pc_ex,
  output logic [XLEN-1:0]  imm_ex,
  output logic [XLEN-1:0]  rs1_data_ex,
  output logic [XLEN-1:0]  rs2_data_ex,
  output logic [4:0]       rs1_ex,
  output logic [4:0]       rs2_ex,
  output logic [4:0]       rd_ex,
  output logic             RUWr_ex,
  output logic             MemRd_ex,
  output logic             MemWr_ex,
  output logic             Branch_ex,
  output logic [3:0]       ALUOp_ex,
  // hazard requests
  output logic             stall_if_id,
  output logic             flush_id,
  // performance debug
  output logic [CNT_W-1:0] lu_bubbles,
  output logic [CNT_W-1:0] br_bubbles
);

  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);
  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  // ---------------------------------------------------------------------------
  // ID/EX state
  // ---------------------------------------------------------------------------
  logic            valid_q,    valid_d;
  logic [XLEN-1:0] pc_q,       pc_d;
  logic [XLEN-1:0] imm_q,      imm_d;
  logic [XLEN-1:0] rs1_data_q, rs1_data_d;
  logic [XLEN-1:0] rs2_data_q, rs2_data_d;
  logic [4:0]      rs1_q,      rs1_d;
  logic [4:0]      rs2_q,      rs2_d;
  logic [4:0]      rd_q,       rd_d;
  logic            ruwr_q,     ruwr_d;
  logic            memrd_q,    memrd_d;
  logic            memwr_q,    memwr_d;
  logic            branch_q,   branch_d;
  logic [3:0]      aluop_q,    aluop_d;

  logic [CNT_W-1:0] lu_cnt_q, lu_cnt_d;
  logic [CNT_W-1:0] br_cnt_q, br_cnt_d;

  // ---------------------------------------------------------------------------
  // Hazard detection
  // ---------------------------------------------------------------------------
  logic rs1_match;
  logic rs2_match;
  logic lu;
  logic take_decode;

  assign rs1_match = uses_rs1_id & (rs1_id == rd_q);
  assign rs2_match = uses_rs2_id & (rs2_id == rd_q);

  // x0 is never a real destination, so a load to x0 cannot create a hazard.
  assign lu = valid_q & memrd_q & (rd_q != 5'd0) & valid_id & (rs1_match | rs2_match);

  // A taken branch squashes the dependent instruction too, so it overrides lu.
  assign flush_id    = ~rst & ~hold & br_taken_ex;
  assign stall_if_id = ~rst & (hold | (lu & ~br_taken_ex));

  // Decode fields are captured only when no flush, no load-use stall and a
  // real instruction; every other non-hold case loads a bubble.
  assign take_decode = ~br_taken_ex & ~lu & valid_id;

  // ---------------------------------------------------------------------------
  // Next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    valid_d    = valid_q;
    pc_d       = pc_q;
    imm_d      = imm_q;
    rs1_data_d = rs1_data_q;
    rs2_data_d = rs2_data_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    rd_d       = rd_q;
    ruwr_d     = ruwr_q;
    memrd_d    = memrd_q;
    memwr_d    = memwr_q;
    branch_d   = branch_q;
    aluop_d    = aluop_q;

    if (!hold) begin
      if (take_decode) begin
        valid_d    = 1'b1;
        pc_d       = pc_id;
        imm_d      = imm_id;
        rs1_data_d = rs1_data_id;
        rs2_data_d = rs2_data_id;
        rs1_d      = rs1_id;
        rs2_d      = rs2_id;
        rd_d       = rd_id;
        ruwr_d     = RUWr_id;
        memrd_d    = MemRd_id;
        memwr_d    = MemWr_id;
        branch_d   = Branch_id;
        aluop_d    = ALUOp_id;
      end else begin
        // Bubble: zero indices guarantee no forwarding match downstream.
        valid_d    = 1'b0;
        pc_d       = '0;
        imm_d      = '0;
        rs1_data_d = '0;
        rs2_data_d = '0;
        rs1_d      = '0;
        rs2_d      = '0;
        rd_d       = '0;
        ruwr_d     = 1'b0;
        memrd_d    = 1'b0;
        memwr_d    = 1'b0;
        branch_d   = 1'b0;
        aluop_d    = '0;
      end
    end
  end

  always_comb begin
    lu_cnt_d = lu_cnt_q;
    br_cnt_d = br_cnt_q;
    if (!hold) begin
      if (br_taken_ex) begin
        if (br_cnt_q != CntMax) br_cnt_d = br_cnt_q + CntOne;
      end else if (lu) begin
        if (lu_cnt_q != CntMax) lu_cnt_d = lu_cnt_q + CntOne;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= 1'b0;
      pc_q       <= '0;
      imm_q      <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      ruwr_q     <= 1'b0;
      memrd_q    <= 1'b0;
      memwr_q    <= 1'b0;
      branch_q   <= 1'b0;
      aluop_q    <= '0;
      lu_cnt_q   <= '0;
      br_cnt_q   <= '0;
    end else begin
      valid_q    <= valid_d;
      pc_q       <= pc_d;
      imm_q      <= imm_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      rd_q       <= rd_d;
      ruwr_q     <= ruwr_d;
      memrd_q    <= memrd_d;
      memwr_q    <= memwr_d;
      branch_q   <= branch_d;
      aluop_q    <= aluop_d;
      lu_cnt_q   <= lu_cnt_d;
      br_cnt_q   <= br_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign valid_ex    = valid_q;
  assign pc_ex       = pc_q;
  assign imm_ex      = imm_q;
  assign rs1_data_ex = rs1_data_q;
  assign rs2_data_ex = rs2_data_q;
  assign rs1_ex      = rs1_q;
  assign rs2_ex      = rs2_q;
  assign rd_ex       = rd_q;
  assign RUWr_ex     = ruwr_q;
  assign MemRd_ex    = memrd_q;
  assign MemWr_ex    = memwr_q;
  assign Branch_ex   = branch_q;
  assign ALUOp_ex    = aluop_q;
  assign lu_bubbles  = lu_cnt_q;
  assign br_bubbles  = br_cnt_q;

endmodule

// File: tb/tb_id_ex_hazard_stage.sv
// Self-checking bench for id_ex_hazard_stage. A default instance and a
// CNT_W=2 instance share all inputs; a behavioural model tracks the expected
// EX contents and bubble counts from the stage's priority rules.
module tb_id_ex_hazard_stage;

  localparam int XLEN = 32;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] d1;
    logic [XLEN-1:0] d2;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            ruwr;
    logic            memrd;
    logic            memwr;
    logic            branch;
    logic [3:0]      aluop;
  } ex_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic valid_id, uses_rs1_id, uses_rs2_id;
  logic RUWr_id, MemRd_id, MemWr_id, Branch_id, br_taken_ex, hold;
  logic [XLEN-1:0] pc_id, imm_id, rs1_data_id, rs2_data_id;
  logic [4:0] rs1_id, rs2_id, rd_id;
  logic [3:0] ALUOp_id;

  logic valid_ex, RUWr_ex, MemRd_ex, MemWr_ex, Branch_ex, stall_if_id, flush_id;
  logic [XLEN-1:0] pc_ex, imm_ex, rs1_data_ex, rs2_data_ex;
  logic [4:0] rs1_ex, rs2_ex, rd_ex;
  logic [3:0] ALUOp_ex;
  logic [15:0] lu_bubbles, br_bubbles;

  logic valid_ex2, RUWr_ex2, MemRd_ex2, MemWr_ex2, Branch_ex2, stall2, flush2;
  logic [XLEN-1:0] pc_ex2, imm_ex2, rs1_data_ex2, rs2_data_ex2;
  logic [4:0] rs1_ex2, rs2_ex2, rd_ex2;
  logic [3:0] ALUOp_ex2;
  logic [1:0] lu_bubbles2, br_bubbles2;

  id_ex_hazard_stage #(.XLEN(XLEN), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .valid_id(valid_id), .pc_id(pc_id), .imm_id(imm_id),
    .rs1_data_id(rs1_data_id), .rs2_data_id(rs2_data_id), .rs1_id(rs1_id), .rs2_id(rs2_id),
    .rd_id(rd_id), .uses_rs1_id(uses_rs1_id), .uses_rs2_id(uses_rs2_id), .RUWr_id(RUWr_id),
    .MemRd_id(MemRd_id), .MemWr_id(MemWr_id), .Branch_id(Branch_id), .ALUOp_id(ALUOp_id),
    .br_taken_ex(br_taken_ex), .hold(hold), .valid_ex(valid_ex), .pc_ex(pc_ex),
    .imm_ex(imm_ex), .rs1_data_ex(rs1_data_ex), .rs2_data_ex(rs2_data_ex), .rs1_ex(rs1_ex),
    .rs2_ex(rs2_ex), .rd_ex(rd_ex), .RUWr_ex(RUWr_ex), .MemRd_ex(MemRd_ex),
    .MemWr_ex(MemWr_ex), .Branch_ex(Branch_ex), .ALUOp_ex(ALUOp_ex),
    .stall_if_id(stall_if_id), .flush_id(flush_id), .lu_bubbles(lu_bubbles),
    .br_bubbles(br_bubbles)
  );

  id_ex_hazard_stage #(.XLEN(XLEN), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .valid_id(valid_id), .pc_id(pc_id), .imm_id(imm_id),
    .rs1_data_id(rs1_data_id), .rs2_data_id(rs2_data_id), .rs1_id(rs1_id), .rs2_id(rs2_id),
    .rd_id(rd_id), .uses_rs1_id(uses_rs1_id), .uses_rs2_id(uses_rs2_id), .RUWr_id(RUWr_id),
    .MemRd_id(MemRd_id), .MemWr_id(MemWr_id), .Branch_id(Branch_id), .ALUOp_id(ALUOp_id),
    .br_taken_ex(br_taken_ex), .hold(hold), .valid_ex(valid_ex2), .pc_ex(pc_ex2),
    .imm_ex(imm_ex2), .rs1_data_ex(rs1_data_ex2), .rs2_data_ex(rs2_data_ex2),
    .rs1_ex(rs1_ex2), .rs2_ex(rs2_ex2), .rd_ex(rd_ex2), .RUWr_ex(RUWr_ex2),
    .MemRd_ex(MemRd_ex2), .MemWr_ex(MemWr_ex2), .Branch_ex(Branch_ex2), .ALUOp_ex(ALUOp_ex2),
    .stall_if_id(stall2), .flush_id(flush2), .lu_bubbles(lu_bubbles2),
    .br_bubbles(br_bubbles2)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  ex_t         m_ex = '0;
  logic [15:0] m_lu = '0, m_br = '0;
  logic [1:0]  m_lu2 = '0, m_br2 = '0;
  int          n_vec = 0;
  int          n_err = 0;

  function automatic ex_t decode_fields();
    ex_t e;
    e.valid = 1'b1;  e.pc = pc_id;  e.imm = imm_id;  e.d1 = rs1_data_id;
    e.d2 = rs2_data_id;  e.rs1 = rs1_id;  e.rs2 = rs2_id;  e.rd = rd_id;
    e.ruwr = RUWr_id;  e.memrd = MemRd_id;  e.memwr = MemWr_id;
    e.branch = Branch_id;  e.aluop = ALUOp_id;
    return e;
  endfunction

  function automatic logic model_lu();
    return m_ex.valid && m_ex.memrd && (m_ex.rd != 0) && valid_id &&
           ((uses_rs1_id && rs1_id == m_ex.rd) || (uses_rs2_id && rs2_id == m_ex.rd));
  endfunction

  function automatic logic exp_stall();
    return !rst && (hold || (model_lu() && !br_taken_ex));
  endfunction

  function automatic logic exp_flush();
    return !rst && !hold && br_taken_ex;
  endfunction

  function automatic void model_step();
    logic lu;
    lu = model_lu();
    if (rst) begin
      m_ex = '0; m_lu = '0; m_br = '0; m_lu2 = '0; m_br2 = '0;
    end else if (hold) begin
      // frozen
    end else if (br_taken_ex) begin
      m_ex = '0;
      if (m_br != 16'hffff) m_br = m_br + 1;
      if (m_br2 != 2'd3) m_br2 = m_br2 + 1;
    end else if (lu) begin
      m_ex = '0;
      if (m_lu != 16'hffff) m_lu = m_lu + 1;
      if (m_lu2 != 2'd3) m_lu2 = m_lu2 + 1;
    end else if (valid_id) begin
      m_ex = decode_fields();
    end else begin
      m_ex = '0;
    end
  endfunction

  function automatic ex_t got_ex();
    ex_t e;
    e.valid = valid_ex;  e.pc = pc_ex;  e.imm = imm_ex;  e.d1 = rs1_data_ex;
    e.d2 = rs2_data_ex;  e.rs1 = rs1_ex;  e.rs2 = rs2_ex;  e.rd = rd_ex;
    e.ruwr = RUWr_ex;  e.memrd = MemRd_ex;  e.memwr = MemWr_ex;
    e.branch = Branch_ex;  e.aluop = ALUOp_ex;
    return e;
  endfunction

  // Advance one clock; the model updates from the inputs sampled on the edge.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic clear_inputs();
    valid_id = 0; uses_rs1_id = 0; uses_rs2_id = 0; RUWr_id = 0; MemRd_id = 0;
    MemWr_id = 0; Branch_id = 0; br_taken_ex = 0; hold = 0; ALUOp_id = '0;
    pc_id = '0; imm_id = '0; rs1_data_id = '0; rs2_data_id = '0;
    rs1_id = '0; rs2_id = '0; rd_id = '0;
  endtask

  task automatic random_decode();
    valid_id = 1'($urandom_range(0, 4) != 0);
    pc_id = $urandom; imm_id = $urandom; rs1_data_id = $urandom; rs2_data_id = $urandom;
    rs1_id = 5'($urandom_range(0, 3)); rs2_id = 5'($urandom_range(0, 3));
    rd_id = 5'($urandom_range(0, 3));
    uses_rs1_id = 1'($urandom); uses_rs2_id = 1'($urandom);
    RUWr_id = 1'($urandom); MemRd_id = 1'($urandom); MemWr_id = 1'($urandom);
    Branch_id = 1'($urandom); ALUOp_id = 4'($urandom);
  endtask

  task automatic drive_instr(input logic [31:0] pc, input logic [4:0] rs1, input logic u1,
                             input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                             input logic memrd);
    valid_id = 1; pc_id = pc; rs1_id = rs1; uses_rs1_id = u1; rs2_id = rs2;
    uses_rs2_id = u2; rd_id = rd; MemRd_id = memrd; RUWr_id = 1;
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1;
    for (int i = 0; i < 2; i++) begin
      random_decode();
      hold = 1'($urandom); br_taken_ex = 1'($urandom);
      #2;
      n_vec++;
      if ({stall_if_id, flush_id} !== 2'b00) begin
        n_err++;
        $display("FAIL reset_comb: stall/flush=%b required 00", {stall_if_id, flush_id});
      end
      tick();
    end
    rst = 0;
    clear_inputs();
    #2;
    n_vec++;
    if (got_ex() !== ex_t'('0) || lu_bubbles !== 0 || br_bubbles !== 0) begin
      n_err++;
      $display("FAIL reset_state: ex=%h lu=%0d br=%0d required all 0",
               got_ex(), lu_bubbles, br_bubbles);
    end
    n_vec++;
    if ({stall_if_id, flush_id} !== 2'b00) begin
      n_err++;
      $display("FAIL reset_release: stall/flush=%b required 00", {stall_if_id, flush_id});
    end
  endtask

  task automatic test_passthrough();
    clear_inputs();
    drive_instr(32'h100, 5'd0, 0, 5'd0, 0, 5'd5, 0);
    ALUOp_id = 4'd3;
    tick();
    n_vec++;
    if (pc_ex !== 32'h100 || rd_ex !== 5'd5 || RUWr_ex !== 1'b1 || ALUOp_ex !== 4'd3 ||
        valid_ex !== 1'b1) begin
      n_err++;
      $display("FAIL passthrough: pc=%h rd=%0d ruwr=%b aluop=%0d valid=%b required 100 5 1 3 1",
               pc_ex, rd_ex, RUWr_ex, ALUOp_ex, valid_ex);
    end
  endtask

  task automatic test_load_use();
    logic [15:0] lu0;
    clear_inputs();
    lu0 = m_lu;
    drive_instr(32'h200, 5'd0, 0, 5'd0, 0, 5'd7, 1);  // load x7
    tick();
    drive_instr(32'h204, 5'd1, 1, 5'd7, 1, 5'd8, 0);  // reads x7 via rs2
    #2;
    n_vec++;
    if (stall_if_id !== 1'b1 || flush_id !== 1'b0) begin
      n_err++;
      $display("FAIL lu_stall: stall=%b flush=%b required 1 0", stall_if_id, flush_id);
    end
    tick();
    n_vec++;
    if (valid_ex !== 1'b0 || rd_ex !== 5'd0 || lu_bubbles !== lu0 + 16'd1) begin
      n_err++;
      $display("FAIL lu_bubble: valid=%b rd=%0d lu=%0d required 0 0 %0d",
               valid_ex, rd_ex, lu_bubbles, lu0 + 16'd1);
    end
    n_vec++;
    if (stall_if_id !== 1'b0) begin
      n_err++;
      $display("FAIL lu_one_cycle: stall=%b required 0", stall_if_id);
    end
    tick();
    n_vec++;
    if (valid_ex !== 1'b1 || pc_ex !== 32'h204 || rd_ex !== 5'd8) begin
      n_err++;
      $display("FAIL lu_dependent: valid=%b pc=%h rd=%0d required 1 204 8",
               valid_ex, pc_ex, rd_ex);
    end
    // Same load, but the consumer does not read rs2.
    drive_instr(32'h300, 5'd0, 0, 5'd0, 0, 5'd7, 1);
    tick();
    drive_instr(32'h304, 5'd1, 1, 5'd7, 0, 5'd8, 0);
    #2;
    n_vec++;
    if (stall_if_id !== 1'b0) begin
      n_err++;
      $display("FAIL lu_unused_src: stall=%b required 0", stall_if_id);
    end
    tick();
    // Load to x0 never stalls.
    drive_instr(32'h400, 5'd0, 0, 5'd0, 0, 5'd0, 1);
    tick();
    drive_instr(32'h404, 5'd0, 1, 5'd0, 1, 5'd8, 0);
    #2;
    n_vec++;
    if (stall_if_id !== 1'b0) begin
      n_err++;
      $display("FAIL lu_rd_zero: stall=%b required 0", stall_if_id);
    end
    tick();
  endtask

  task automatic test_branch_flush();
    clear_inputs();
    rst = 1;
    tick();
    rst = 0;
    drive_instr(32'h500, 5'd0, 0, 5'd0, 0, 5'd7, 1);
    tick();
    drive_instr(32'h504, 5'd0, 0, 5'd7, 1, 5'd9, 0);
    br_taken_ex = 1;
    #2;
    n_vec++;
    if (flush_id !== 1'b1 || stall_if_id !== 1'b0) begin
      n_err++;
      $display("FAIL br_over_lu: flush=%b stall=%b required 1 0", flush_id, stall_if_id);
    end
    tick();
    n_vec++;
    if (valid_ex !== 1'b0 || rd_ex !== 5'd0 || br_bubbles !== 16'd1 || lu_bubbles !== 16'd0) begin
      n_err++;
      $display("FAIL br_bubble: valid=%b rd=%0d br=%0d lu=%0d required 0 0 1 0",
               valid_ex, rd_ex, br_bubbles, lu_bubbles);
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_hold();
    ex_t         held;
    logic [15:0] lu0;
    logic [15:0] br0;
    clear_inputs();
    drive_instr(32'h600, 5'd2, 1, 5'd3, 1, 5'd9, 1);
    imm_id = 32'h44; ALUOp_id = 4'd2;
    tick();
    held = '0;
    held.valid = 1; held.pc = 32'h600; held.imm = 32'h44; held.rs1 = 5'd2;
    held.rs2 = 5'd3; held.rd = 5'd9; held.ruwr = 1; held.memrd = 1; held.aluop = 4'd2;
    lu0 = m_lu; br0 = m_br;
    for (int i = 0; i < 3; i++) begin
      random_decode();
      hold = 1;
      if (i == 1) begin
        valid_id = 1; rs1_id = 5'd9; uses_rs1_id = 1;  // load-use during hold
      end
      if (i == 2) br_taken_ex = 1;
      #2;
      n_vec++;
      if (stall_if_id !== 1'b1 || flush_id !== 1'b0) begin
        n_err++;
        $display("FAIL hold_req[%0d]: stall=%b flush=%b required 1 0", i, stall_if_id, flush_id);
      end
      tick();
      br_taken_ex = 0;
      n_vec++;
      if (got_ex() !== held || lu_bubbles !== lu0 || br_bubbles !== br0) begin
        n_err++;
        $display("FAIL hold_keep[%0d]: ex=%h lu=%0d br=%0d required ex=%h lu=%0d br=%0d",
                 i, got_ex(), lu_bubbles, br_bubbles, held, lu0, br0);
      end
    end
    clear_inputs();
    drive_instr(32'h700, 5'd1, 0, 5'd1, 0, 5'd4, 0);
    #2;
    n_vec++;
    if (stall_if_id !== 1'b0) begin
      n_err++;
      $display("FAIL hold_release_stall: stall=%b required 0", stall_if_id);
    end
    tick();
    n_vec++;
    if (valid_ex !== 1'b1 || pc_ex !== 32'h700 || rd_ex !== 5'd4) begin
      n_err++;
      $display("FAIL hold_release: valid=%b pc=%h rd=%0d required 1 700 4",
               valid_ex, pc_ex, rd_ex);
    end
  endtask

  task automatic test_saturation();
    clear_inputs();
    rst = 1;
    tick();
    rst = 0;
    for (int i = 0; i < 5; i++) begin
      drive_instr(32'h800 + 32'(i * 16), 5'd0, 0, 5'd0, 0, 5'd3, 1);
      tick();
      drive_instr(32'h804 + 32'(i * 16), 5'd3, 1, 5'd0, 0, 5'd6, 0);
      tick();  // bubble
      tick();  // dependent enters EX
    end
    n_vec++;
    if (lu_bubbles2 !== 2'd3 || lu_bubbles !== 16'd5 || br_bubbles2 !== 2'd0) begin
      n_err++;
      $display("FAIL saturation: lu2=%0d lu=%0d br2=%0d required 3 5 0",
               lu_bubbles2, lu_bubbles, br_bubbles2);
    end
    clear_inputs();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      random_decode();
      rst = 1'($urandom_range(0, 49) == 0);
      hold = 1'($urandom_range(0, 9) == 0);
      br_taken_ex = 1'($urandom_range(0, 7) == 0);
      #2;
      n_vec++;
      if (stall_if_id !== exp_stall() || flush_id !== exp_flush() ||
          stall2 !== exp_stall() || flush2 !== exp_flush()) begin
        n_err++;
        $display("FAIL rand_comb[%0d]: stall=%b flush=%b required %b %b",
                 i, stall_if_id, flush_id, exp_stall(), exp_flush());
      end
      tick();
      n_vec++;
      if (got_ex() !== m_ex || lu_bubbles !== m_lu || br_bubbles !== m_br ||
          lu_bubbles2 !== m_lu2 || br_bubbles2 !== m_br2 || pc_ex2 !== m_ex.pc ||
          rd_ex2 !== m_ex.rd || valid_ex2 !== m_ex.valid) begin
        n_err++;
        $display("FAIL rand_state[%0d]: ex=%h lu=%0d br=%0d lu2=%0d br2=%0d required ex=%h lu=%0d br=%0d lu2=%0d br2=%0d",
                 i, got_ex(), lu_bubbles, br_bubbles, lu_bubbles2, br_bubbles2,
                 m_ex, m_lu, m_br, m_lu2, m_br2);
      end
    end
    rst = 0;
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    rst = 1;
    #1;
    test_reset();
    test_passthrough();
    test_load_use();
    test_branch_flush();
    test_hold();
    test_saturation();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
